// File: rtl/mips16_pkg.sv
// Shared definitions for the MIPS16 pipeline: datapath widths, the bubble
// instruction, the reset PC and the fetch-stage state encoding.
package mips16_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 16;

  localparam logic [PC_W-1:0]   RESET_PC = 16'h0000;
  localparam logic [INST_W-1:0] NOP      = 16'h0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DELIVER = 2'd2,
    S_DROP    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register: instruction, its PC+1 and the ready qualifier.
// load takes priority over clear; with neither asserted everything holds.
module if_id_reg
  import mips16_pkg::*;
#(
  parameter int                  ADDR_W       = PC_W,
  parameter int                  DATA_W       = INST_W,
  parameter logic [DATA_W-1:0]   CLR_INST     = NOP,
  parameter logic [ADDR_W-1:0]   RST_PC_PLUS1 = RESET_PC + 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] inst_in,
  input  logic [ADDR_W-1:0] pc_plus1_in,
  output logic [DATA_W-1:0] instout,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              ready
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instout  <= CLR_INST;
      pc_plus1 <= RST_PC_PLUS1;
      ready    <= 1'b0;
    end else if (load) begin
      instout  <= inst_in;
      pc_plus1 <= pc_plus1_in;
      ready    <= 1'b1;
    end else if (clear) begin
      // pc_plus1 is left alone; only the instruction becomes a bubble
      instout  <= CLR_INST;
      ready    <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem and
// hands instructions to ID through if_id_reg. Branches squash in-flight fetches.
module if_fetch #(
  parameter int                  PC_W     = mips16_pkg::PC_W,
  parameter int                  INST_W   = mips16_pkg::INST_W,
  parameter logic [PC_W-1:0]     RESET_PC = mips16_pkg::RESET_PC,
  parameter logic [INST_W-1:0]   NOP      = mips16_pkg::NOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_valid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] instout,
  output logic [PC_W-1:0]   pc_plus1,
  output logic              ready
);

  import mips16_pkg::*;

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] pc_inc;
  logic            req, load, clear;

  assign pc_inc    = pc_reg + 1'b1;  // wraps silently at the top of the space
  assign imem_addr = pc_reg;
  assign imem_req  = req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    req        = 1'b0;
    load       = 1'b0;
    clear      = 1'b0;

    case (state_reg)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        req = 1'b1;
        if (imem_valid) begin
          load       = 1'b1;
          pc_next    = pc_inc;
          state_next = S_DELIVER;
        end
      end

      S_DELIVER: begin
        // A live instruction blocked by ID freezes everything. When ready is
        // low a request may already be in flight, so it must stay asserted.
        if (!(stall && ready)) begin
          req = 1'b1;
          if (imem_valid) begin
            load    = 1'b1;
            pc_next = pc_inc;
          end else begin
            clear = 1'b1;
          end
        end
      end

      S_DROP: begin
        if (imem_valid) state_next = S_FETCH;
      end

      default: state_next = S_IDLE;
    endcase

    if (branch_taken) begin
      pc_next = branch_target;
      load    = 1'b0;
      clear   = 1'b1;
      if ((req || state_reg == S_DROP) && !imem_valid) state_next = S_DROP;
      else                                             state_next = S_FETCH;
    end
  end

  if_id_reg #(
    .ADDR_W      (PC_W),
    .DATA_W      (INST_W),
    .CLR_INST    (NOP),
    .RST_PC_PLUS1(RESET_PC + 1'b1)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .clear      (clear),
    .inst_in    (imem_rdata),
    .pc_plus1_in(pc_inc),
    .instout    (instout),
    .pc_plus1   (pc_plus1),
    .ready      (ready)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a variable-latency imem responder plus a scoreboard of
// instructions that ID is expected to accept, one scenario task per feature.
module tb_if_fetch;

  localparam logic [15:0] NOP_V = 16'h0000;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pcp1;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [15:0] instout;
  logic [15:0] pc_plus1;
  logic        ready;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // imem responder state; lat = cycles a request is held, 1 = zero-wait
  int          lat = 1;
  int          cnt;
  logic        busy;
  logic [15:0] paddr;
  logic        man_en;
  logic        man_valid;
  logic [15:0] man_rdata;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h2280;
  endfunction

  if_fetch dut (
    .clk          (clk),
    .reset        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .instout      (instout),
    .pc_plus1     (pc_plus1),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_valid = man_en ? man_valid : ((busy || imem_req) && cnt == lat - 1);
  assign imem_rdata = man_en ? man_rdata : mem_word(busy ? paddr : imem_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= 0;
      paddr <= 16'h0000;
    end else if (imem_valid) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (busy || imem_req) begin
      if (!busy) paddr <= imem_addr;
      busy <= 1'b1;
      cnt  <= cnt + 1;
    end
  end

  task automatic push_exp(input logic [15:0] a, input logic [15:0] p1);
    exp_t e;
    e.inst = mem_word(a);
    e.pcp1 = p1;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    man_en = 1'b0; man_valid = 1'b0; man_rdata = 16'h0000;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    man_en = 1'b0; man_valid = 1'b0; man_rdata = 16'h0000; lat = 1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b0 || instout !== NOP_V) begin
      n_fail++; $display("FAIL rst_out: ready=%b instout=%h, expected 0 %h", ready, instout, NOP_V);
    end
    n_checks++;
    if (pc_plus1 !== 16'h0001) begin
      n_fail++; $display("FAIL rst_pcp1: pc_plus1=%h, expected 0001", pc_plus1);
    end
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL rst_imem: req=%b addr=%h, expected 0 0000", imem_req, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: req=%b, expected 0", imem_req);
    end
    $display("reset checked");
  endtask

  // zero-wait memory: addresses 0..3 on consecutive cycles, then stall on the last
  task automatic test_zero_wait();
    exp_t e;
    int   first_ready;
    first_ready = -1;
    lat = 1;
    for (int a = 0; a < 4; a++) push_exp(16'(a), 16'(a + 1));
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      stall = ready && (sb.size() == 1);
      #1;
      if (ready && first_ready < 0) first_ready = c;
      if (ready && !stall) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL t1_deliver: inst=%h, expected no delivery", instout);
        end else begin
          e = sb.pop_front();
          if (instout !== e.inst || pc_plus1 !== e.pcp1) begin
            n_fail++; $display("FAIL t1_deliver: inst=%h pc_plus1=%h, expected %h %h", instout, pc_plus1, e.inst, e.pcp1);
          end else $display("t1 deliver inst=%h pc_plus1=%h", instout, pc_plus1);
        end
      end else if (!ready) begin
        n_checks++;
        if (instout !== NOP_V) begin
          n_fail++; $display("FAIL t1_bubble: instout=%h, expected %h", instout, NOP_V);
        end
      end
      if (imem_req) begin
        n_checks++;
        if (imem_addr !== 16'(c - 1) || imem_valid !== 1'b1) begin
          n_fail++; $display("FAIL t1_addr: addr=%h valid=%b, expected %h 1", imem_addr, imem_valid, 16'(c - 1));
        end
      end
      if (stall) break;
    end
    n_checks++;
    if (first_ready !== 2 || sb.size() != 1) begin
      n_fail++; $display("FAIL t1_timing: first ready cycle %0d queue %0d, expected 2 and 1", first_ready, sb.size());
    end
  endtask

  // three-cycle memory: each address held for exactly three request cycles
  task automatic test_latency();
    exp_t        e;
    int          run;
    logic [15:0] exp_addr, prev_addr;
    lat = 3; run = 0; exp_addr = 16'h0004; prev_addr = 16'h0000;
    push_exp(16'h0004, 16'h0005);
    push_exp(16'h0005, 16'h0006);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      stall = ready && (sb.size() == 1);
      #1;
      if (ready && !stall) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL t2_deliver: inst=%h, expected no delivery", instout);
        end else begin
          e = sb.pop_front();
          if (instout !== e.inst || pc_plus1 !== e.pcp1) begin
            n_fail++; $display("FAIL t2_deliver: inst=%h pc_plus1=%h, expected %h %h", instout, pc_plus1, e.inst, e.pcp1);
          end else $display("t2 deliver inst=%h pc_plus1=%h", instout, pc_plus1);
        end
      end else if (!ready) begin
        n_checks++;
        if (instout !== NOP_V) begin
          n_fail++; $display("FAIL t2_bubble: instout=%h, expected %h", instout, NOP_V);
        end
      end
      if (imem_req) begin
        run++;
        if (run > 1) begin
          n_checks++;
          if (imem_addr !== prev_addr) begin
            n_fail++; $display("FAIL t2_stable: addr=%h, expected %h", imem_addr, prev_addr);
          end
        end
        prev_addr = imem_addr;
        if (imem_valid) begin
          n_checks++;
          if (run !== 3 || imem_addr !== exp_addr) begin
            n_fail++; $display("FAIL t2_wait: addr=%h held %0d, expected %h held 3", imem_addr, run, exp_addr);
          end
          exp_addr = exp_addr + 16'h0001;
          run = 0;
        end
      end
      if (stall) break;
    end
    n_checks++;
    if (exp_addr !== 16'h0006 || sb.size() != 1) begin
      n_fail++; $display("FAIL t2_done: next addr %h queue %0d, expected 0006 and 1", exp_addr, sb.size());
    end
  endtask

  // held for four stalled cycles on 16'h2285, then resumes at pc_plus1
  task automatic test_stall();
    exp_t e;
    lat = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      n_checks++;
      if (ready !== 1'b1 || instout !== 16'h2285 || pc_plus1 !== 16'h0006 || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL t3_hold: ready=%b inst=%h pc_plus1=%h req=%b, expected 1 2285 0006 0", ready, instout, pc_plus1, imem_req);
      end else $display("t3 hold cycle %0d inst=%h", c, instout);
    end
    push_exp(16'h0006, 16'h0007);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      stall = 1'b0;
      #1;
      if (c == 1) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
          n_fail++; $display("FAIL t3_resume: req=%b addr=%h, expected 1 0006", imem_req, imem_addr);
        end
      end
      if (ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL t3_deliver: inst=%h, expected no delivery", instout);
        end else begin
          e = sb.pop_front();
          if (instout !== e.inst || pc_plus1 !== e.pcp1) begin
            n_fail++; $display("FAIL t3_deliver: inst=%h pc_plus1=%h, expected %h %h", instout, pc_plus1, e.inst, e.pcp1);
          end else $display("t3 deliver inst=%h pc_plus1=%h", instout, pc_plus1);
        end
      end
      if (sb.size() == 0) break;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL t3_done: %0d instructions undelivered, expected 0", sb.size());
    end
  endtask

  // branch while the fetch of 5 is outstanding: late data dropped
  task automatic test_branch_drop();
    exp_t e;
    apply_reset();
    lat = 3;
    branch_taken = 1'b1; branch_target = 16'h0005;
    push_exp(16'h0040, 16'h0041);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      branch_taken  = (c == 2);
      branch_target = (c == 2) ? 16'h0040 : 16'h0005;
      #1;
      if (c == 1 || c == 2) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin
          n_fail++; $display("FAIL t4_fetch5: req=%b addr=%h, expected 1 0005", imem_req, imem_addr);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (imem_req !== 1'b0) begin
          n_fail++; $display("FAIL t4_drop: req=%b addr=%h, expected req 0", imem_req, imem_addr);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
          n_fail++; $display("FAIL t4_target: req=%b addr=%h, expected 1 0040", imem_req, imem_addr);
        end
      end
      if (ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL t4_deliver: inst=%h, expected no delivery", instout);
        end else begin
          e = sb.pop_front();
          if (instout !== e.inst || pc_plus1 !== e.pcp1) begin
            n_fail++; $display("FAIL t4_deliver: inst=%h pc_plus1=%h, expected %h %h", instout, pc_plus1, e.inst, e.pcp1);
          end else $display("t4 deliver inst=%h pc_plus1=%h", instout, pc_plus1);
        end
      end else begin
        n_checks++;
        if (instout !== NOP_V) begin
          n_fail++; $display("FAIL t4_bubble: instout=%h, expected %h", instout, NOP_V);
        end
      end
      if (sb.size() == 0) break;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL t4_timeout: %0d instructions undelivered, expected 0", sb.size());
    end
  endtask

  // branch and imem_valid together while stalled
  task automatic test_branch_valid_stall();
    exp_t e;
    apply_reset();
    lat = 1;
    push_exp(16'h0080, 16'h0081);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      stall         = (c <= 2);
      branch_taken  = (c == 1);
      branch_target = 16'h0080;
      #1;
      if (c == 1) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_valid !== 1'b1 || imem_addr !== 16'h0000) begin
          n_fail++; $display("FAIL t5_setup: req=%b valid=%b addr=%h, expected 1 1 0000", imem_req, imem_valid, imem_addr);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
          n_fail++; $display("FAIL t5_target: req=%b addr=%h, expected 1 0080", imem_req, imem_addr);
        end
      end
      if (ready && !stall) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL t5_deliver: inst=%h, expected no delivery", instout);
        end else begin
          e = sb.pop_front();
          if (instout !== e.inst || pc_plus1 !== e.pcp1) begin
            n_fail++; $display("FAIL t5_deliver: inst=%h pc_plus1=%h, expected %h %h", instout, pc_plus1, e.inst, e.pcp1);
          end else $display("t5 deliver inst=%h pc_plus1=%h", instout, pc_plus1);
        end
      end else if (!ready) begin
        n_checks++;
        if (instout !== NOP_V) begin
          n_fail++; $display("FAIL t5_bubble: instout=%h, expected %h", instout, NOP_V);
        end
      end
      if (sb.size() == 0) break;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL t5_timeout: %0d instructions undelivered, expected 0", sb.size());
    end
  endtask

  // PC wrap at FFFF, then reset in the middle of a wait with a stale valid
  task automatic test_wrap_and_reset();
    exp_t e;
    apply_reset();
    lat = 1;
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    push_exp(16'hFFFF, 16'h0000);
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin
      n_fail++; $display("FAIL t6_fetch: req=%b addr=%h, expected 1 ffff", imem_req, imem_addr);
    end
    @(negedge clk);
    lat = 3;
    #1;
    n_checks++;
    if (!ready || sb.size() == 0) begin
      n_fail++; $display("FAIL t6_deliver: ready=%b, expected 1", ready);
    end else begin
      e = sb.pop_front();
      if (instout !== e.inst || pc_plus1 !== e.pcp1) begin
        n_fail++; $display("FAIL t6_deliver: inst=%h pc_plus1=%h, expected %h %h", instout, pc_plus1, e.inst, e.pcp1);
      end else $display("t6 deliver inst=%h pc_plus1=%h", instout, pc_plus1);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL t6_wrap: req=%b addr=%h, expected 1 0000", imem_req, imem_addr);
    end
    #2;
    rst_n = 1'b0; man_en = 1'b1; man_valid = 1'b1; man_rdata = 16'hBEEF;
    #1;
    n_checks++;
    if (ready !== 1'b0 || instout !== NOP_V || pc_plus1 !== 16'h0001) begin
      n_fail++; $display("FAIL t6_async: ready=%b inst=%h pc_plus1=%h, expected 0 %h 0001", ready, instout, pc_plus1, NOP_V);
    end
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL t6_async_imem: req=%b addr=%h, expected 0 0000", imem_req, imem_addr);
    end
    push_exp(16'h0000, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL t6_idle: req=%b ready=%b, expected 0 0", imem_req, ready);
    end
    @(negedge clk);
    man_en = 1'b0; man_valid = 1'b0; lat = 1;
    #1;
    n_checks++;
    if (ready !== 1'b0 || instout !== NOP_V || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL t6_stale: ready=%b inst=%h req=%b addr=%h, expected 0 %h 1 0000", ready, instout, imem_req, imem_addr, NOP_V);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (!ready || sb.size() == 0) begin
      n_fail++; $display("FAIL t6_restart: ready=%b, expected 1", ready);
    end else begin
      e = sb.pop_front();
      if (instout !== e.inst || pc_plus1 !== e.pcp1) begin
        n_fail++; $display("FAIL t6_restart: inst=%h pc_plus1=%h, expected %h %h", instout, pc_plus1, e.inst, e.pcp1);
      end else $display("t6 deliver inst=%h pc_plus1=%h", instout, pc_plus1);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_branch_drop();
    test_branch_valid_stall();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
